uart_tx_param: RTL

// - Parametrised UART transmitter; successor to the fixed 8-bit, 1-clock-per-bit Tx top.
// - Adds: data width parameter, runtime baud prescaler, 1/2 stop bits, one-entry holding register.
// - The holding register allows back-to-back frames with no idle gap.
// - Sits between the parallel producer (valid/ready) and the serial TX pin.

---
 rtl/uart_tx_param.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//   Parametrised UART transmitter with runtime baud prescaler, optional
//   parity, 1/2 stop bits and a one-entry holding register.
//   The holding register lets frames go out back to back with no idle gap.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9)
//   PRESCALE_W  width of PRESCALE
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   PRESCALE    bit period = PRESCALE+1 clocks (captured with the data)
//   PAR_EN      1 = parity bit present
//   PAR_TYP     0 = even parity, 1 = odd parity
//   STOP2       0 = one stop bit, 1 = two stop bits
//   Data_Valid  P_DATA valid this cycle
//   P_DATA      parallel data, sent LSB first
//   BREAK       (UART_TX_BREAK_EN only) hold line low while in idle
//   Ready       holding register empty; accept = Data_Valid & Ready
//   TX_OUT      serial line, idle high
//   Busy        frame (or break) in progress
//
// Build option
//   UART_TX_BREAK_EN  adds the BREAK input and the BRK state.
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK,
`endif
  output logic                  Ready,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  // Everything the producer hands over with one accept.
  typedef struct packed {
    logic [PRESCALE_W-1:0] pre;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic [DATA_WIDTH-1:0] data;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
`ifdef UART_TX_BREAK_EN
    , S_BRK
`endif
  } state_e;

  state_e                state_q, state_d;
  frame_t                hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  pen_q, pen_d;
  logic                  stp2_q, stp2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
`ifdef UART_TX_BREAK_EN
  // Set on leaving BRK: idle must last one full bit period before a START.
  logic                  guard_q, guard_d;
`endif

  logic accept;
  logic bit_end;
  logic load;       // move holding register into the shifter, enter START
  logic last_stop;  // final stop bit of the current frame ends this cycle

  assign accept  = Data_Valid & ready_q;
  assign bit_end = (cnt_q == pre_q);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    par_d      = par_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    pen_d      = pen_q;
    stp2_d     = stp2_q;
`ifdef UART_TX_BREAK_EN
    guard_d    = guard_q;
`endif
    load       = 1'b0;
    last_stop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef UART_TX_BREAK_EN
        if (BREAK) begin
          state_d = S_BRK;
          guard_d = 1'b0;
        end else if (guard_q) begin
          if (cnt_q == pre_q) begin
            guard_d = 1'b0;
            load    = hold_vld_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          load = hold_vld_q;
        end
`else
        load = hold_vld_q;
`endif
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = pen_q ? S_PARITY : S_STOP1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP1: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stp2_q) state_d = S_STOP2;
          else        last_stop = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP2: begin
        if (bit_end) begin
          cnt_d     = '0;
          last_stop = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        cnt_d = '0;
        if (!BREAK) begin
          state_d = S_IDLE;
          guard_d = 1'b1;
          pre_d   = PRESCALE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A queued frame follows the last stop bit with no idle cycle.
    if (last_stop) begin
      if (hold_vld_q) load = 1'b1;
      else            state_d = S_IDLE;
    end

    // Latch the whole frame config so port changes mid-frame are harmless.
    if (load) begin
      state_d    = S_START;
      cnt_d      = '0;
      shift_d    = hold_q.data;
      par_d      = hold_q.par_typ ? ~^hold_q.data : ^hold_q.data;
      pre_d      = hold_q.pre;
      pen_d      = hold_q.par_en;
      stp2_d     = hold_q.stop2;
      hold_vld_d = 1'b0;
    end

    // Applied after the drain so a same-edge accept refills the register.
    if (accept) begin
      hold_d     = '{pre: PRESCALE, par_en: PAR_EN, par_typ: PAR_TYP,
                     stop2: STOP2, data: P_DATA};
      hold_vld_d = 1'b1;
    end

    ready_d = ~hold_vld_d;
  end

  // Outputs are decoded from next state so they register on the same edge
  // as the state change.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
`ifdef UART_TX_BREAK_EN
      S_BRK:    tx_d = 1'b0;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      pre_q      <= '0;
      pen_q      <= 1'b0;
      stp2_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      guard_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ready_q    <= ready_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      pen_q      <= pen_d;
      stp2_q     <= stp2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_BREAK_EN
      guard_q    <= guard_d;
`endif
    end
  end

  assign Ready  = ready_q;
  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
